// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared default widths, reset vector and branch-kind encodings for the fetch unit
package instr_fetch_pkg;
    localparam int DEF_ADDR_SIZE    = 11;
    localparam int DEF_RAM_WIDTH    = 22;
    localparam int DEF_STACK_DEPTH  = 8;
    localparam int DEF_RESET_VECTOR = 0;
    typedef enum logic [1:0] {
        BR_JMP  = 2'b00,
        BR_REL  = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_kind_e;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: redirect inputs, program-memory bus and fetched-instruction outputs; slave = fetch unit, master = its environment
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int RAM_WIDTH = DEF_RAM_WIDTH
);
    logic                 stall;
    logic                 br_valid;
    logic [1:0]           br_kind;
    logic [ADDR_SIZE-1:0] br_target;
    logic [ADDR_SIZE-1:0] br_pc;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_rd_enb;
    logic [RAM_WIDTH-1:0] mem_data;
    logic [RAM_WIDTH-1:0] instr;
    logic [ADDR_SIZE-1:0] instr_pc;
    logic                 instr_valid;
    logic                 stack_ovf;
    logic                 stack_unf;
    modport slave (
        input  stall, br_valid, br_kind, br_target, br_pc, mem_data,
        output mem_addr, mem_rd_enb, instr, instr_pc, instr_valid, stack_ovf, stack_unf
    );
    modport master (
        output stall, br_valid, br_kind, br_target, br_pc, mem_data,
        input  mem_addr, mem_rd_enb, instr, instr_pc, instr_valid, stack_ovf, stack_unf
    );
endinterface

// File: rtl/instr_fetch_call_stack.sv
// call_stack: synchronous LIFO return stack; push/pop with din/dout, full/empty flags, push-when-full and pop-when-empty ignored
module call_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    top_idx;
    assign top_idx = IW'(cnt_q - CW'(1));
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign dout    = mem_q[top_idx];
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push && !full) begin
            mem_d[IW'(cnt_q)] = din;
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencer with redirects and return stack; clk/rst plus bus (stall, br_*, mem_*, instr*, stack flags)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int RAM_WIDTH    = DEF_RAM_WIDTH,
    parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
    parameter int RESET_VECTOR = DEF_RESET_VECTOR
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);
    localparam logic [ADDR_SIZE-1:0] RV = ADDR_SIZE'(RESET_VECTOR);
    logic [ADDR_SIZE-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d, rel, tgt, stk_dout;
    logic valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic rd, push, pop, stk_full, stk_empty;
    call_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_SIZE)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.br_pc + ADDR_SIZE'(1)),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );
    always_comb begin
        rd   = !rst && !bus.stall && !bus.br_valid;
        push = bus.br_valid && bus.br_kind == BR_CALL;
        pop  = bus.br_valid && bus.br_kind == BR_RET;
        // unsigned add wraps identically to a signed offset modulo 2^ADDR_SIZE
        rel  = bus.br_pc + bus.br_target;
        tgt  = bus.br_kind == BR_JMP ? bus.br_target :
               bus.br_kind == BR_RET ? (stk_empty ? RV : stk_dout) : rel;
        pc_d       = bus.br_valid ? tgt : rd ? pc_q + ADDR_SIZE'(1) : pc_q;
        instr_pc_d = rd ? pc_q : instr_pc_q;
        valid_d    = bus.br_valid ? 1'b0 : rd ? 1'b1 : valid_q;
        ovf_d      = ovf_q || (push && stk_full);
        unf_d      = unf_q || (pop && stk_empty);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RV;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end
    assign bus.mem_addr    = pc_q;
    assign bus.mem_rd_enb  = rd;
    assign bus.instr       = bus.mem_data;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus for instr_fetch checked against a queue-based fetch model
module tb_instr_fetch;
    import instr_fetch_pkg::*;
    localparam int AW   = DEF_ADDR_SIZE;
    localparam int DW   = DEF_RAM_WIDTH;
    localparam int SD   = DEF_STACK_DEPTH;
    localparam int RV   = DEF_RESET_VECTOR;
    localparam int MASK = (1 << AW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    instr_fetch_if bus ();
    instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rdata = '0;
    always @(posedge clk) if (bus.mem_rd_enb) rdata <= mem[bus.mem_addr];
    assign bus.mem_data = rdata;
    int n_cmp = 0;
    int n_err = 0;
    int m_pc, m_ipc, m_valid, m_data, m_ovf, m_unf;
    int stk[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_state();
        chk("mem_addr", 32'(bus.mem_addr), m_pc);
        chk("instr_valid", 32'(bus.instr_valid), m_valid);
        chk("instr_pc", 32'(bus.instr_pc), m_ipc);
        chk("instr", 32'(bus.instr), m_data);
        chk("stack_ovf", 32'(bus.stack_ovf), m_ovf);
        chk("stack_unf", 32'(bus.stack_unf), m_unf);
    endtask
    task automatic model_reset();
        m_pc = RV; m_ipc = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
        stk.delete();
    endtask
    task automatic do_reset(input int n, input bit chk_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_first || i > 0) check_state();
            rst = 1'b1;
            bus.stall = 1'($urandom);
            bus.br_valid = 1'($urandom);
            bus.br_kind = 2'($urandom);
            bus.br_target = AW'($urandom);
            bus.br_pc = AW'($urandom);
            #1 chk("rst_rd_enb", 32'(bus.mem_rd_enb), 0);
            @(posedge clk);
            model_reset();
        end
    endtask
    task automatic step(input bit st, input bit bv, input int kind, input int tgt, input int bpc);
        int off;
        @(negedge clk);
        check_state();
        rst = 1'b0;
        bus.stall = st;
        bus.br_valid = bv;
        bus.br_kind = 2'(kind);
        bus.br_target = AW'(tgt);
        bus.br_pc = AW'(bpc);
        #1 chk("mem_rd_enb", 32'(bus.mem_rd_enb), 32'(!st && !bv));
        @(posedge clk);
        off = (tgt & MASK) >= (1 << (AW - 1)) ? (tgt & MASK) - (1 << AW) : (tgt & MASK);
        if (bv) begin
            if (kind == 0) m_pc = tgt & MASK;
            else if (kind == 1) m_pc = (bpc + off) & MASK;
            else if (kind == 2) begin
                if (stk.size() < SD) stk.push_back((bpc + 1) & MASK);
                else m_ovf = 1;
                m_pc = (bpc + off) & MASK;
            end else begin
                if (stk.size() > 0) m_pc = stk.pop_back();
                else begin
                    m_pc = RV;
                    m_unf = 1;
                end
            end
            m_valid = 0;
        end else if (!st) begin
            m_data = int'(mem[m_pc]);
            m_ipc = m_pc;
            m_valid = 1;
            m_pc = (m_pc + 1) & MASK;
        end
    endtask
    initial begin
        for (int k = 0; k <= MASK; k++) mem[k] = DW'(k);
        bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_kind = '0;
        bus.br_target = '0; bus.br_pc = '0;
        m_data = 0;
        model_reset();
        do_reset(2, 1'b0);
        repeat (5) step(0, 0, 0, 0, 0);
        #1 chk("pc5", 32'(bus.mem_addr), 5);
        chk("ipc4", 32'(bus.instr_pc), 4);
        chk("instr4", 32'(bus.instr), 4);
        repeat (3) step(1, 0, 0, 0, 0);
        #1 chk("stall_ipc", 32'(bus.instr_pc), 4);
        chk("stall_instr", 32'(bus.instr), 4);
        chk("stall_pc", 32'(bus.mem_addr), 5);
        step(0, 0, 0, 0, 0);
        #1 chk("resume_ipc", 32'(bus.instr_pc), 5);
        step(0, 1, BR_CALL, 186, 14);
        #1 chk("call_tgt", 32'(bus.mem_addr), 200);
        chk("call_squash", 32'(bus.instr_valid), 0);
        step(1, 0, 0, 0, 0);
        #1 chk("call_stall_squash", 32'(bus.instr_valid), 0);
        step(0, 0, 0, 0, 0);
        #1 chk("call_fetch_ipc", 32'(bus.instr_pc), 200);
        chk("call_fetch_valid", 32'(bus.instr_valid), 1);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, BR_RET, 0, 0);
        #1 chk("ret_tgt", 32'(bus.mem_addr), 15);
        step(0, 1, BR_REL, 'h7FD, 3);
        #1 chk("rel_neg", 32'(bus.mem_addr), 0);
        step(0, 1, BR_JMP, 2047, 0);
        step(0, 0, 0, 0, 0);
        #1 chk("wrap", 32'(bus.mem_addr), 0);
        chk("wrap_ipc", 32'(bus.instr_pc), 2047);
        do_reset(1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, BR_CALL, 5, 100 * i);
            #1 chk("nest_ovf", 32'(bus.stack_ovf), 32'(i == 8));
        end
        for (int j = 0; j < 9; j++) begin
            step(0, 1, BR_RET, 0, 0);
            #1 chk("nest_ret", 32'(bus.mem_addr), j < 8 ? 100 * (7 - j) + 1 : RV);
            chk("nest_unf", 32'(bus.stack_unf), 32'(j == 8));
        end
        step(1, 1, BR_JMP, 100, 0);
        #1 chk("stall_redirect", 32'(bus.mem_addr), 100);
        do_reset(1, 1'b1);
        #1 chk("rst_pc", 32'(bus.mem_addr), RV);
        chk("rst_ovf", 32'(bus.stack_ovf), 0);
        chk("rst_unf", 32'(bus.stack_unf), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        repeat (600) begin
            if ($urandom_range(99) < 2) do_reset(1, 1'b1);
            else step($urandom_range(3) == 0, $urandom_range(5) == 0, int'($urandom_range(3)),
                      int'($urandom_range(MASK)), int'($urandom_range(MASK)));
        end
        @(negedge clk);
        check_state();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_SIZE, default 11: program address width.
REQ-002 Parameter RAM_WIDTH, default 22: instruction word width.
REQ-003 Parameter STACK_DEPTH, default 8: return-stack entries.
REQ-004 Parameter RESET_VECTOR, default 0: first fetch address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall  in  1  downstream not ready; hold fetch.
REQ-008 br_valid  in  1  redirect request from execute.
REQ-009 br_kind  in  2  00 jump-absolute, 01 jump-relative, 10 call-relative, 11 return.
REQ-010 br_target  in  ADDR_SIZE  absolute target (00) or two's-complement offset (01/10); ignored for 11.
REQ-011 br_pc  in  ADDR_SIZE  address of the branching instruction.
REQ-012 mem_addr  out  ADDR_SIZE  program-memory address; equals PC register.
REQ-013 mem_rd_enb  out  1  program-memory read enable.
REQ-014 mem_data  in  RAM_WIDTH  program-memory read data, one-cycle latency.
REQ-015 instr  out  RAM_WIDTH  fetched instruction; direct pass-through of mem_data.
REQ-016 instr_pc  out  ADDR_SIZE  address of instr.
REQ-017 instr_valid  out  1  instr/instr_pc meaningful.
REQ-018 stack_ovf  out  1  sticky: call with full stack.
REQ-019 stack_unf  out  1  sticky: return with empty stack.

Function
REQ-020 mem_rd_enb SHALL be 1 exactly when stall=0, br_valid=0 and rst=0.
REQ-021 Fetch cycle (mem_rd_enb=1): PC <= PC+1 modulo 2^ADDR_SIZE; issued address registered into instr_pc; instr_valid <= 1.
REQ-022 Stall cycle (stall=1, br_valid=0): PC, instr_pc, instr_valid hold; instr holds because memory read is disabled.
REQ-023 Redirect cycle (br_valid=1): overrides stall; PC <= target; instr_valid <= 0 (in-flight fetch squashed); instr_pc holds.
REQ-024 Target: 00 br_target; 01 br_pc + br_target; 10 br_pc + br_target, also push br_pc+1; 11 top of stack, popped.
REQ-025 Relative sums SHALL treat br_target as signed ADDR_SIZE-bit and wrap modulo 2^ADDR_SIZE.
REQ-026 Redirect penalty: target fetched in first non-stalled cycle after redirect; instr_valid rises one cycle later.
REQ-027 Call with STACK_DEPTH entries: push dropped, stack unchanged, stack_ovf <= 1, jump still taken.
REQ-028 Return with empty stack: PC <= RESET_VECTOR, stack_unf <= 1.
REQ-029 Stack is LIFO; push and pop never occur in the same cycle (one br_kind per cycle).
REQ-030 stack_ovf/stack_unf SHALL stay set until rst.
REQ-031 br_valid=0 SHALL leave br_kind, br_target, br_pc ignored.

Reset
REQ-032 rst=1 at any edge: PC <= RESET_VECTOR, instr_pc <= 0, instr_valid <= 0, stack emptied, stack_ovf <= 0, stack_unf <= 0; rst overrides br_valid and stall.
REQ-033 During rst mem_rd_enb=0; first fetch of RESET_VECTOR in first cycle with rst=0 and stall=0.
REQ-034 Reset mid-redirect or mid-stall SHALL discard pending state; no stale instr_valid after reset.

Structure
REQ-035 Shared package: ADDR_SIZE, RAM_WIDTH, STACK_DEPTH, RESET_VECTOR defaults and br_kind encodings (BR_JMP, BR_REL, BR_CALL, BR_RET).
REQ-036 Return stack SHALL be a sub-module call_stack (push, pop, data in/out, full, empty), synchronous, reset to empty.
REQ-037 No combinational path from mem_data to any output except instr.

Verification
REQ-038 Reset release, no stall, memory preloaded mem[k]=k -> mem_addr 0,1,2,...; instr_valid 1 from cycle 2; instr_pc=k alongside instr=k.
REQ-039 stall=1 for 3 cycles at PC=5 -> mem_rd_enb=0, instr/instr_pc/instr_valid frozen at 4; fetch resumes at 5.
REQ-040 Call br_pc=14, br_target=186 -> next fetch 200; return later -> fetch 15; no instruction from the squashed slot marked valid.
REQ-041 Jump-relative br_pc=3, br_target=-3 (0x7FD) -> fetch 0; PC=2047 sequential -> wraps to 0.
REQ-042 Nine nested calls -> stack_ovf=1 after ninth; nine returns -> eighth returns correct addresses, ninth sets stack_unf and fetches RESET_VECTOR.
REQ-043 br_valid=1 with stall=1, then rst=1 next cycle -> redirect taken, then PC=0, flags clear, instr_valid=0.
